executor: RTL and testbench
===========================

EXECUTOR -- requirements
Module: executor

Interface
REQ-001 SHALL have parameter NUM_VARS, default 16, number of 8-bit variable registers (power of two, 2..16), indexed by token value[3:0] modulo NUM_VARS.
REQ-002 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port I_VALID  input  1  token present this cycle, no backpressure.
REQ-005 SHALL have port I_DATA  input  16  token {kind[15:8], value[7:0]}.
REQ-006 SHALL have port OUT_VALID  output  1  one-cycle pulse, OUT_DATA valid.
REQ-007 SHALL have port OUT_DATA  output  8  result of the last completed out statement.
REQ-008 SHALL have port ERROR  output  1  sticky syntax-error flag.
REQ-009 SHALL have port DONE  output  1  sticky end-of-program flag.

Function
REQ-010 SHALL decode kinds: 00 SEMICOLON, 01 OUT, 02 VAR, 03 EQUAL, 04 IF, 05/06 brackets, 07 SHIFT_L, 08 SHIFT_R, 09 PLUS, 0A MINUS, 0B NUM (value = literal), 0C EOF; any other kind is illegal.
REQ-011 SHALL accept one token on every cycle with I_VALID=1; no token is dropped or stalled except in HALT.
REQ-012 SHALL implement grammar: stmt = VAR EQUAL expr SEMICOLON | OUT expr SEMICOLON; expr = term {op term}; term = VAR | NUM; op = PLUS | MINUS | SHIFT_L | SHIFT_R.
REQ-013 SHALL use states IDLE, EXP_EQ, EXP_TERM, EXP_OP, SKIP, HALT; reset state IDLE.
REQ-014 IDLE: VAR -> latch dest index, EXP_EQ; OUT -> set out flag, EXP_TERM; EOF -> HALT; SEMICOLON -> stay (empty statement); other -> error.
REQ-015 EXP_EQ: EQUAL -> EXP_TERM; other -> error.
REQ-016 EXP_TERM: term -> acc = first term or acc op term, EXP_OP; other -> error.
REQ-017 EXP_OP: op -> latch pending op, EXP_TERM; SEMICOLON -> commit, IDLE; other -> error.
REQ-018 Evaluation SHALL be strictly left to right, 8-bit, modulo 256 for PLUS/MINUS; shifts are logical, by the full 8-bit right operand, amount >=8 yielding 0.
REQ-019 Commit SHALL write acc into the dest variable, or, for out, drive OUT_DATA=acc with OUT_VALID=1 for exactly the cycle after the SEMICOLON edge.
REQ-020 A variable written by a commit SHALL be readable by a VAR term in the very next accepted token (write-then-read, no hazard).
REQ-021 A VAR term SHALL read the current register value; an unwritten variable reads 0.
REQ-022 Error SHALL set ERROR, discard the partial statement (no variable write, no OUT_VALID), enter SKIP; SKIP discards tokens until SEMICOLON -> IDLE.
REQ-023 EOF in any state other than HALT SHALL set DONE and enter HALT; EOF outside IDLE also sets ERROR and discards the partial statement.
REQ-024 HALT SHALL ignore all tokens until reset; DONE asserts the cycle after the EOF edge.
REQ-025 OUT_DATA SHALL hold its value between pulses.

Reset
REQ-026 RST low SHALL immediately clear OUT_VALID, OUT_DATA, ERROR, DONE, acc, pending op, all variables to 0 and force IDLE, aborting any statement in progress.
REQ-027 Tokens presented while RST is low SHALL be ignored; the first token after release is decoded in IDLE.

Configuration
REQ-028 With EXECUTOR_SHIFT_EN defined, SHIFT_L/SHIFT_R SHALL be operators per REQ-018.
REQ-029 Without EXECUTOR_SHIFT_EN, SHIFT_L/SHIFT_R SHALL be illegal in every state (error per REQ-022) and no shifter logic SHALL be built.

Verification
REQ-030 0261,0300,0B05,0001,0100,0261,0001 -> single OUT_VALID pulse, OUT_DATA=05, ERROR=0.
REQ-031 0100,0BFA,0900,0B0A,0001 then 0100,0B03,0A00,0B05,0001 -> OUT_DATA=04 then FE.
REQ-032 0100,0B01,0700,0B03,0001 -> with EXECUTOR_SHIFT_EN OUT_DATA=08; without, ERROR=1 and no OUT_VALID.
REQ-033 0261,0300,0300,0B01,0001,0100,0B07,0001 -> ERROR=1, variable a unchanged (0), one pulse OUT_DATA=07.
REQ-034 0262,0300,0B09,0001,0263,0300,0262,0900,0262,0001,0100,0263,0001 back-to-back -> OUT_DATA=12.
REQ-035 0100,0B05,0C00 -> DONE=1 and ERROR=1, no pulse; following 0100,0B01,0001 ignored; RST low mid-statement -> all outputs 0, IDLE.

Source files
------------

// File: rtl/executor.sv
// executor: token-stream interpreter for "var = expr;" and "out expr;" statements over 8-bit variables.
// Define EXECUTOR_SHIFT_EN to accept SHIFT_L/SHIFT_R as operators; otherwise they are illegal tokens.
`default_nettype none
module executor #(
  parameter int NUM_VARS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_VALID,
  input  logic [15:0] I_DATA,
  output logic        OUT_VALID,
  output logic [7:0]  OUT_DATA,
  output logic        ERROR,
  output logic        DONE
);

  localparam int IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;

  localparam logic [7:0] K_SEMI  = 8'h00;
  localparam logic [7:0] K_OUT   = 8'h01;
  localparam logic [7:0] K_VAR   = 8'h02;
  localparam logic [7:0] K_EQUAL = 8'h03;
  localparam logic [7:0] K_PLUS  = 8'h09;
  localparam logic [7:0] K_MINUS = 8'h0A;
  localparam logic [7:0] K_NUM   = 8'h0B;
  localparam logic [7:0] K_EOF   = 8'h0C;
`ifdef EXECUTOR_SHIFT_EN
  localparam logic [7:0] K_SHL   = 8'h07;
  localparam logic [7:0] K_SHR   = 8'h08;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_EXP_EQ, S_EXP_TERM, S_EXP_OP, S_SKIP, S_HALT
  } state_e;

  // OP_LOAD marks the first term of an expression: acc simply takes the term.
  typedef enum logic [2:0] {
    OP_LOAD, OP_ADD, OP_SUB, OP_SHL, OP_SHR
  } op_e;

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [7:0]           acc_q, acc_d;
  logic [IDX_W-1:0]     dest_q, dest_d;
  logic                 is_out_q, is_out_d;
  logic                 out_valid_q, out_valid_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 error_q, error_d;
  logic                 done_q, done_d;
  logic [7:0]           vars_q [NUM_VARS];
  logic                 var_we;

  logic [7:0]           kind;
  logic [7:0]           value;
  logic [IDX_W-1:0]     idx;
  logic                 is_term;
  logic [7:0]           term;
  logic                 is_op;
  op_e                  tok_op;

  assign kind  = I_DATA[15:8];
  assign value = I_DATA[7:0];
  assign idx   = I_DATA[IDX_W-1:0];

  assign is_term = (kind == K_VAR) || (kind == K_NUM);
  assign term    = (kind == K_VAR) ? vars_q[idx] : value;

  function automatic logic [7:0] alu(input op_e op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
`ifdef EXECUTOR_SHIFT_EN
      OP_SHL:  return a << b;
      OP_SHR:  return a >> b;
`endif
      default: return b;
    endcase
  endfunction

  always_comb begin
    is_op  = 1'b1;
    tok_op = OP_ADD;
    case (kind)
      K_PLUS:  tok_op = OP_ADD;
      K_MINUS: tok_op = OP_SUB;
`ifdef EXECUTOR_SHIFT_EN
      K_SHL:   tok_op = OP_SHL;
      K_SHR:   tok_op = OP_SHR;
`endif
      default: is_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    dest_d      = dest_q;
    is_out_d    = is_out_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    error_d     = error_q;
    done_d      = done_q;
    var_we      = 1'b0;

    if (I_VALID) begin
      if (kind == K_EOF && state_q != S_HALT) begin
        done_d  = 1'b1;
        state_d = S_HALT;
        if (state_q != S_IDLE) error_d = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (kind == K_VAR) begin
              dest_d   = idx;
              is_out_d = 1'b0;
              op_d     = OP_LOAD;
              state_d  = S_EXP_EQ;
            end else if (kind == K_OUT) begin
              is_out_d = 1'b1;
              op_d     = OP_LOAD;
              state_d  = S_EXP_TERM;
            end else if (kind != K_SEMI) begin
              error_d = 1'b1;
              state_d = S_SKIP;
            end
          end
          S_EXP_EQ: begin
            if (kind == K_EQUAL) begin
              state_d = S_EXP_TERM;
            end else begin
              error_d = 1'b1;
              state_d = S_SKIP;
            end
          end
          S_EXP_TERM: begin
            if (is_term) begin
              acc_d   = alu(op_q, acc_q, term);
              state_d = S_EXP_OP;
            end else begin
              error_d = 1'b1;
              state_d = S_SKIP;
            end
          end
          S_EXP_OP: begin
            if (is_op) begin
              op_d    = tok_op;
              state_d = S_EXP_TERM;
            end else if (kind == K_SEMI) begin
              // Commit happens on this edge so the next token already sees the new value.
              if (is_out_q) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_q;
              end else begin
                var_we = 1'b1;
              end
              state_d = S_IDLE;
            end else begin
              error_d = 1'b1;
              state_d = S_SKIP;
            end
          end
          S_SKIP: begin
            if (kind == K_SEMI) state_d = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOAD;
      acc_q       <= '0;
      dest_q      <= '0;
      is_out_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < NUM_VARS; i++) vars_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      dest_q      <= dest_d;
      is_out_q    <= is_out_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      error_q     <= error_d;
      done_q      <= done_d;
      if (var_we) vars_q[dest_q] <= acc_q;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign ERROR     = error_q;
  assign DONE      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_executor.sv
// Directed self-checking bench for executor with hand-computed expected values.
`default_nettype none
module tb_executor;

  logic        CLK;
  logic        RST;
  logic        I_VALID;
  logic [15:0] I_DATA;
  logic        OUT_VALID;
  logic [7:0]  OUT_DATA;
  logic        ERROR;
  logic        DONE;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int p0;

  executor #(.NUM_VARS(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .I_VALID   (I_VALID),
    .I_DATA    (I_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_DATA  (OUT_DATA),
    .ERROR     (ERROR),
    .DONE      (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (OUT_VALID === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; on return the token's effect is visible.
  task automatic send(input logic [15:0] t);
    I_VALID = 1'b1;
    I_DATA  = t;
    @(negedge CLK);
    I_VALID = 1'b0;
    I_DATA  = 16'h0;
  endtask

  task automatic idle();
    I_VALID = 1'b0;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    I_VALID = 1'b0;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b0; I_VALID = 1'b0; I_DATA = 16'h0;
    repeat (2) @(negedge CLK);
    check("rst_ovalid", OUT_VALID, 0);
    check("rst_odata",  OUT_DATA,  0);
    check("rst_error",  ERROR,     0);
    check("rst_done",   DONE,      0);
    RST = 1'b1;
    @(negedge CLK);

    // a = 5; out a;
    p0 = pulses;
    send(16'h0261); send(16'h0300); send(16'h0B05); send(16'h0001);
    send(16'h0100); send(16'h0261); send(16'h0001);
    check("r30_pulse_now", OUT_VALID, 1);
    idle();
    check("r30_pulse_gone", OUT_VALID, 0);
    check("r30_npulse", pulses - p0, 1);
    check("r30_data", OUT_DATA, 8'h05);
    check("r30_error", ERROR, 0);
    idle();
    check("hold_data", OUT_DATA, 8'h05);

    // modulo add and subtract wrap
    send(16'h0100); send(16'h0BFA); send(16'h0900); send(16'h0B0A); send(16'h0001);
    check("r31_add", OUT_DATA, 8'h04);
    send(16'h0100); send(16'h0B03); send(16'h0A00); send(16'h0B05); send(16'h0001);
    check("r31_sub", OUT_DATA, 8'hFE);
    idle();

    // shift operator, build dependent
    p0 = pulses;
    send(16'h0100); send(16'h0B01); send(16'h0700); send(16'h0B03); send(16'h0001);
    idle();
`ifdef EXECUTOR_SHIFT_EN
    check("r32_data", OUT_DATA, 8'h08);
    check("r32_npulse", pulses - p0, 1);
    check("r32_error", ERROR, 0);
    p0 = pulses;
    send(16'h0100); send(16'h0B80); send(16'h0800); send(16'h0B09); send(16'h0001);
    check("shr_big", OUT_DATA, 8'h00);
`else
    check("r32_error", ERROR, 1);
    check("r32_npulse", pulses - p0, 0);
    check("r32_data_kept", OUT_DATA, 8'hFE);
`endif
    do_reset();

    // syntax error mid-statement, then recovery
    p0 = pulses;
    send(16'h0261); send(16'h0300); send(16'h0300); send(16'h0B01); send(16'h0001);
    check("r33_error", ERROR, 1);
    send(16'h0100); send(16'h0B07); send(16'h0001);
    idle();
    check("r33_npulse", pulses - p0, 1);
    check("r33_data", OUT_DATA, 8'h07);
    send(16'h0100); send(16'h0261); send(16'h0001);
    check("r33_a_unchanged", OUT_DATA, 8'h00);
    do_reset();

    // illegal kind in IDLE
    send(16'h0D00); send(16'h0B01); send(16'h0001);
    check("illegal_error", ERROR, 1);
    send(16'h0100); send(16'h0B02); send(16'h0001);
    check("illegal_recover", OUT_DATA, 8'h02);
    do_reset();

    // back-to-back write-then-read, empty statement, index modulo
    send(16'h0001);
    send(16'h0262); send(16'h0300); send(16'h0B09); send(16'h0001);
    send(16'h0263); send(16'h0300); send(16'h0262); send(16'h0900); send(16'h0262); send(16'h0001);
    send(16'h0100); send(16'h0263); send(16'h0001);
    check("r34_data", OUT_DATA, 8'h12);
    check("r34_error", ERROR, 0);
    send(16'h0100); send(16'h0272); send(16'h0001);
    check("idx_modulo", OUT_DATA, 8'h09);
    do_reset();

    // EOF mid-statement
    p0 = pulses;
    send(16'h0100); send(16'h0B05); send(16'h0C00);
    check("r35_done", DONE, 1);
    check("r35_error", ERROR, 1);
    send(16'h0100); send(16'h0B01); send(16'h0001);
    idle();
    check("r35_npulse", pulses - p0, 0);
    check("r35_data", OUT_DATA, 8'h00);
    do_reset();

    // EOF in IDLE: done without error
    send(16'h0C00);
    check("eof_idle_done", DONE, 1);
    check("eof_idle_error", ERROR, 0);
    do_reset();

    // asynchronous reset mid-statement
    send(16'h0261); send(16'h0300); send(16'h0B33); send(16'h0001);
    send(16'h0100); send(16'h0261); send(16'h0001);
    check("pre_rst_data", OUT_DATA, 8'h33);
    send(16'h0100); send(16'h0B05);
    #2 RST = 1'b0;
    #1;
    check("async_rst_data", OUT_DATA, 8'h00);
    check("async_rst_error", ERROR, 0);
    @(negedge CLK);
    I_VALID = 1'b1; I_DATA = 16'h0001;
    @(negedge CLK);
    I_VALID = 1'b1; I_DATA = 16'h0C00;
    @(negedge CLK);
    I_VALID = 1'b0;
    check("rst_tok_ignored", DONE, 0);
    RST = 1'b1;
    p0 = pulses;
    send(16'h0100); send(16'h0261); send(16'h0001);
    idle();
    check("post_rst_npulse", pulses - p0, 1);
    check("post_rst_var", OUT_DATA, 8'h00);
    check("post_rst_error", ERROR, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
